// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;
  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_W      = 32;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } ifu_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction queue: push, pop, flush (flush wins), occupancy count.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_push,
  input  ifu_entry_t    i_data,
  input  logic          i_pop,
  input  logic          i_flush,
  output ifu_entry_t    o_head,
  output logic [CW-1:0] o_count
);
  ifu_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_pop, w_push;

  // Pop only when occupied; push only when a slot is (or is becoming) free.
  assign w_pop  = i_pop & (r_cnt != '0);
  assign w_push = i_push & ((r_cnt != CW'(DEPTH)) | w_pop);

  // Pointer/count update; storage cleared on reset so the head reads zero.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: credit-limited imem requests, in-order response
// tracking with stale-response discard after redirects, and an instruction queue.
// Optional IFU_PERF_EN adds fetch_cnt_o / drop_cnt_o performance counters.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] drop_cnt_o
`endif
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_fetch_pc, r_resp_pc;
  logic [CW-1:0] r_outstanding, r_discard;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_inflight;
  logic          w_req, w_acc, w_rv, w_drop, w_push, w_pop;
  logic [31:0]   w_redir_pc;
  ifu_entry_t    w_head, w_push_data;
  logic          w_unused_lsb;

  assign w_redir_pc   = {redirect_pc_i[31:2], 2'b00};
  assign w_unused_lsb = ^redirect_pc_i[1:0];

  // Credit rule: in-flight plus buffered never exceeds the queue depth.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_count};
  assign w_req      = rst_i & ~redirect_i & (w_inflight < (CW+1)'(DEPTH));
  assign w_acc      = w_req & imem_gnt_i;

  // A response only counts when something is outstanding; stale ones are dropped.
  assign w_rv   = imem_rvalid_i & (r_outstanding != '0);
  assign w_drop = w_rv & (redirect_i | (r_discard != '0));
  assign w_push = w_rv & ~w_drop;
  assign w_pop  = instr_ready_i & ~redirect_i & instr_valid_o;

  assign w_push_data = '{instr: imem_rdata_i, pc: r_resp_pc};

  ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // PC registers and outstanding/discard accounting; redirect overrides all.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_i) begin
      r_fetch_pc    <= w_redir_pc;
      r_resp_pc     <= w_redir_pc;
      r_outstanding <= r_outstanding - CW'(w_rv);
      r_discard     <= r_outstanding - CW'(w_rv);
    end else begin
      if (w_acc)  r_fetch_pc <= r_fetch_pc + PC_INC;
      if (w_push) r_resp_pc  <= r_resp_pc + PC_INC;
      r_outstanding <= r_outstanding + CW'(w_acc) - CW'(w_rv);
      if (w_rv && (r_discard != '0)) r_discard <= r_discard - CW'(1);
    end
  end

`ifdef IFU_PERF_EN
  // Pops delivered downstream and responses thrown away, both free-running.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_cnt_o <= '0;
      drop_cnt_o  <= '0;
    end else begin
      if (w_pop)  fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (w_drop) drop_cnt_o  <= drop_cnt_o + 32'd1;
    end
  end
`endif

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = (w_count != '0);
  assign instr_o       = w_head.instr;
  assign instr_pc_o    = w_head.pc;
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front-end that sits directly upstream of the single-cycle CPU core's decode path. It issues word-aligned fetch requests to an instruction memory with a request/grant and in-order response handshake, and buffers returned instructions with their PCs in a small queue. It presents the buffered instructions downstream over a valid/ready interface. It also accepts PC redirects from the branch logic, flushing the queue and discarding stale in-flight responses.

## Interface
- DEPTH, 4: queue entries; also the maximum number of in-flight plus buffered fetches (power of two, ≥2)
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk_i  in  1  clock. One clock; reset is synchronous and active-low.
- rst_i  in  1  synchronous active-low reset (sampled on rising clk_i)
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address; bits [1:0] always 0
- imem_gnt_i  in  1  request accepted this cycle (req & gnt)
- imem_rvalid_i  in  1  response valid; responses are in order, at least 1 cycle after grant
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  queue head valid
- instr_o  out  32  queue head instruction
- instr_pc_o  out  32  queue head PC
- instr_ready_i  in  1  consumer accepts the head (pop on valid & ready)
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored (forced 0)

## Operation
- State: fetch_pc, resp_pc, outstanding (0..DEPTH), discard (0..DEPTH), queue count.
- Reset values: fetch_pc = resp_pc = RESET_PC; outstanding = discard = 0; queue empty; imem_req_o = 0; instr_valid_o = 0; instr_o = instr_pc_o = 0; imem_addr_o = RESET_PC.
- Issue: imem_req_o = !redirect_i & (outstanding + count < DEPTH). imem_addr_o = fetch_pc. On req & gnt: fetch_pc += 4 (wraps mod 2^32); outstanding += 1.
- Address stability: while req is high without gnt, imem_addr_o holds its value. Only a redirect changes it.
- Response: on rvalid, outstanding -= 1.
  - If discard > 0: drop the data and discard -= 1.
  - Otherwise: push {imem_rdata_i, resp_pc} into the queue and resp_pc += 4.
- Spurious rvalid with outstanding == 0: ignored with no state change.
- Output: instr_valid_o = count != 0. instr_o and instr_pc_o show the head entry and are held stable until popped.
- Simultaneous push and pop on a non-empty queue: count is unchanged.
- Redirect (highest priority), in the same cycle:
  - queue flushed and any pop ignored;
  - any rvalid data dropped;
  - fetch_pc <= resp_pc <= {redirect_pc_i[31:2], 2'b00};
  - discard <= outstanding - rvalid_i;
  - no request issued.
- Back-to-back redirects: the last one wins, and the discard accounting stays consistent.
- Overflow is impossible by construction through the credit rule. Underflow: a pop on an empty queue is ignored.

## Timing
- Grant at cycle t → earliest rvalid at t+1 → instr_valid_o at t+2 (queue write registered).
- With single-cycle memory latency and an always-ready consumer, the unit sustains one instruction per cycle in steady state.
- Redirect at cycle t: instr_valid_o = 0 at t+1. First new request is issued at t+1 at redirect_pc. First new instruction is valid no earlier than t+3.
- Reset mid-operation: all state returns to reset values on the next edge. In-flight memory responses after reset are not tracked, so the memory is reset together with this unit.

## Configuration
- IFU_PERF_EN defined:
  - adds outputs fetch_cnt_o (32) and drop_cnt_o (32), both reset to 0;
  - fetch_cnt_o counts pops and drop_cnt_o counts discarded responses;
  - both wrap at 2^32.
- IFU_PERF_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package ifu_pkg holds:
  - RESET_PC default;
  - INSTR_W = 32;
  - PC_INC = 4;
  - the queue entry struct {instr, pc}.
- Sub-module ifu_fifo: synchronous FIFO of DEPTH entries with push, pop, flush and count. Flush has priority over push and pop.
- Top-level logic: issue/credit control, the outstanding and discard counters, PC registers, and the optional perf counters.

## Test plan
- Reset then free run (gnt = 1, 1-cycle latency, ready = 1, memory word = address) → instr_pc_o sequence 0, 4, 8, … one per cycle from cycle 3; instr_o equals instr_pc_o.
- ready = 0 held (DEPTH = 4) → exactly 4 grants, then imem_req_o = 0; raising ready gives pops 0, 4, 8, 12 and fetching resumes at 16.
- gnt = 0 for 3 cycles with req high → imem_addr_o constant; fetch_pc advances only on the grant cycle.
- Redirect to 0x100 with 2 responses outstanding (3-cycle latency) → both responses dropped, queue empty next cycle, first delivered instr_pc_o = 0x100 (drop_cnt_o = 2 when IFU_PERF_EN).
- redirect_pc_i = 0x203 → imem_addr_o = 0x200.
- rst_i low mid-stream → next cycle: instr_valid_o = 0, imem_req_o = 0, imem_addr_o = RESET_PC; after release, fetch restarts at RESET_PC.
